// File: rtl/neuai_7seg_pkg.sv
// Shared types, segment codes and BCD-to-segment decoder for the 7-segment display block.
// Latency: combinational helpers only.
// Backpressure: none (constants and functions).
package neuai_7seg_pkg;

   typedef logic [3:0] bcd_digit_t;

   // Segment patterns {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Non-decimal codes are shown dark rather than as garbage
   function automatic logic [6:0] seg_decode(input bcd_digit_t d);
      case (d)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/neuai_tick_gen.sv
// Free-running prescaler: single-cycle tick once every DIV cycles.
// Latency: tick is combinational from the counter; first tick DIV cycles after reset release.
// Backpressure: none; ticks are never held or queued.
module neuai_tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // Count 0..DIV-1 and wrap; DIV=1 degenerates to a tick every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               cnt <= '0;
      else if (cnt == LAST)  cnt <= '0;
      else                   cnt <= cnt + W'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/neuai_led_7seg_scan.sv
// Multi-digit BCD up/down counter with a time-multiplexed 7-segment display driver.
// Latency: count_bcd/wrap update on the edge after a tick; led_7seg/dig lag scan index/count by 1 cycle.
// Backpressure: none; en gates counting, clr overrides ticks.
module neuai_led_7seg_scan
   import neuai_7seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 1,
   parameter int SCAN_HZ    = 1000,
   parameter int LZ_BLANK   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up_dn,
   input  logic                    clr,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [7:0]              led_7seg,
   output logic [NUM_DIGITS-1:0]   dig,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    wrap
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   logic                    tick;
   logic                    scan_tick;
   logic [4*NUM_DIGITS-1:0] count_q;
   logic [4*NUM_DIGITS-1:0] count_nxt;
   logic                    roll;
   logic                    carry;
   bcd_digit_t              d;
   logic [IW-1:0]           idx;
   logic [NUM_DIGITS-1:0]   upper_zero;
   logic                    zero_run;
   bcd_digit_t              cur_digit;
   logic [6:0]              cur_seg;

   neuai_tick_gen #(.DIV(TICK_DIV)) u_count_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   neuai_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (scan_tick)
   );

   // Ripple carry/borrow across digits; a carry out of the top digit is a wrap
   always_comb begin
      count_nxt = count_q;
      carry     = 1'b1;
      d         = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = count_q[4*i +: 4];
         if (carry) begin
            if (up_dn) begin
               if (d == 4'd9) d = 4'd0;
               else begin
                  d     = d + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (d == 4'd0) d = 4'd9;
               else begin
                  d     = d - 4'd1;
                  carry = 1'b0;
               end
            end
         end
         count_nxt[4*i +: 4] = d;
      end
      roll = carry;
   end

   // Count register: clear wins over a tick, wrap is a one-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wrap    <= 1'b0;
      end else if (clr) begin
         count_q <= '0;
         wrap    <= 1'b0;
      end else if (tick && en) begin
         count_q <= count_nxt;
         wrap    <= roll;
      end else begin
         wrap    <= 1'b0;
      end
   end

   // Scan index walks 0..NUM_DIGITS-1 on each scan tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   idx <= '0;
      else if (scan_tick) begin
         if (idx == LAST_IDX)    idx <= '0;
         else                    idx <= idx + IW'(1);
      end
   end

   // Segment pattern for the digit being scanned, with optional leading-zero blanking
   always_comb begin
      upper_zero = '0;
      zero_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run      = zero_run && (count_q[4*i +: 4] == 4'd0);
         upper_zero[i] = zero_run;
      end
      cur_digit = count_q[4*int'(idx) +: 4];
      cur_seg   = seg_decode(cur_digit);
      if ((LZ_BLANK != 0) && (idx != '0) && upper_zero[idx]) cur_seg = SEG_BLANK;
   end

   // Registered display outputs so the pins never glitch mid-cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig      <= '1;
         led_7seg <= 8'h00;
      end else begin
         dig      <= ~(NUM_DIGITS'(1) << idx);
         led_7seg <= {dp_mask[idx], cur_seg};
      end
   end

   assign count_bcd = count_q;

endmodule

// File: tb/tb_neuai_led_7seg_scan.sv
// Self-checking bench: table-driven counter vectors plus hand sequences for scan, blanking, priority and reset.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_neuai_led_7seg_scan;

   logic        clk;
   logic        rst;
   logic        en;
   logic        up_dn;
   logic        clr;
   logic [3:0]  dp_mask;
   logic [7:0]  led_a, led_b;
   logic [3:0]  dig_a, dig_b;
   logic [15:0] cnt_a, cnt_b;
   logic        wrap_a, wrap_b;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc;

   typedef struct {
      logic        clr;
      logic        en;
      logic        up;
      int          nt;
      logic [15:0] cnt;
      logic        wrap;
   } vec_t;

   vec_t tab[9];

   neuai_led_7seg_scan #(
      .NUM_DIGITS(4), .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .LZ_BLANK(0)
   ) u_dut_a (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .dp_mask(dp_mask),
      .led_7seg(led_a), .dig(dig_a), .count_bcd(cnt_a), .wrap(wrap_a)
   );

   neuai_led_7seg_scan #(
      .NUM_DIGITS(4), .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .LZ_BLANK(1)
   ) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .dp_mask(dp_mask),
      .led_7seg(led_b), .dig(dig_b), .count_bcd(cnt_b), .wrap(wrap_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference cycle count since reset release: ticks fall where cyc%10==9, scan steps where cyc%2==1
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stop inside the cycle during which the count prescaler ticks
   task automatic to_tick();
      for (int k = 0; k < 10 && (cyc % 10) != 9; k++) step();
   endtask

   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         to_tick();
         step();
      end
   endtask

   // Observe 8 consecutive cycles of the display; exp_* hold expected led bytes for digits 3..0
   task automatic scan_check(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b);
      int         e;
      logic [3:0] one;
      one = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         step();
         e = ((cyc - 1) / 2) % 4;
         chk($sformatf("%s_dig_d%0d", tag, e), {28'd0, dig_a}, {28'd0, ~(one << e)});
         chk($sformatf("%s_led_d%0d", tag, e), {24'd0, led_a}, {24'd0, exp_a[8*e +: 8]});
         chk($sformatf("%s_lz_led_d%0d", tag, e), {24'd0, led_b}, {24'd0, exp_b[8*e +: 8]});
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_led"},   {24'd0, led_a}, 32'h00);
      chk({tag, "_dig"},   {28'd0, dig_a}, 32'hF);
      chk({tag, "_count"}, {16'd0, cnt_a}, 32'h0000);
      chk({tag, "_wrap"},  {31'd0, wrap_a}, 32'd0);
      chk({tag, "_lz_dig"}, {28'd0, dig_b}, 32'hF);
   endtask

   initial begin
      //           clr   en    up    ticks  count     wrap
      tab[0] = '{1'b1, 1'b1, 1'b1, 10,  16'h0010, 1'b0};
      tab[1] = '{1'b1, 1'b1, 1'b0, 1,   16'h9999, 1'b1};
      tab[2] = '{1'b0, 1'b1, 1'b1, 1,   16'h0000, 1'b1};
      tab[3] = '{1'b1, 1'b1, 1'b1, 100, 16'h0100, 1'b0};
      tab[4] = '{1'b0, 1'b1, 1'b0, 1,   16'h0099, 1'b0};
      tab[5] = '{1'b1, 1'b1, 1'b1, 3,   16'h0003, 1'b0};
      tab[6] = '{1'b0, 1'b0, 1'b1, 5,   16'h0003, 1'b0};
      tab[7] = '{1'b0, 1'b1, 1'b0, 3,   16'h0000, 1'b0};
      tab[8] = '{1'b0, 1'b1, 1'b0, 1,   16'h9999, 1'b1};

      rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; dp_mask = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("init");
      rst = 1'b0;

      // Prescaler starts from zero: first tick lands 10 edges after release
      en = 1'b1; up_dn = 1'b1;
      to_tick();
      chk("pre_first_tick", {16'd0, cnt_a}, 32'h0000);
      step();
      chk("first_tick", {16'd0, cnt_a}, 32'h0001);

      for (int i = 0; i < 9; i++) begin
         en = tab[i].en; up_dn = tab[i].up;
         if (tab[i].clr) begin
            clr = 1'b1;
            step();
            clr = 1'b0;
         end
         run_ticks(tab[i].nt);
         chk($sformatf("vec%0d_count", i), {16'd0, cnt_a}, {16'd0, tab[i].cnt});
         chk($sformatf("vec%0d_wrap", i), {31'd0, wrap_a}, {31'd0, tab[i].wrap});
         chk($sformatf("vec%0d_lz_count", i), {16'd0, cnt_b}, {16'd0, tab[i].cnt});
      end

      // Wrap pulse is exactly one cycle wide
      step();
      chk("wrap_drop", {31'd0, wrap_a}, 32'd0);
      chk("wrap_hold_count", {16'd0, cnt_a}, 32'h9999);

      // clr in the tick cycle beats a wrapping increment
      en = 1'b1; up_dn = 1'b1;
      to_tick();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_on_tick_count", {16'd0, cnt_a}, 32'h0000);
      chk("clr_on_tick_wrap", {31'd0, wrap_a}, 32'd0);

      // Reach 1234 and freeze for the scan check
      run_ticks(1234);
      en = 1'b0;
      chk("count_1234", {16'd0, cnt_a}, 32'h1234);
      dp_mask = 4'b0010;
      step();
      scan_check("s1234", 32'h065BCF66, 32'h065BCF66);

      // Leading-zero blanking on 0007 and 0000
      dp_mask = 4'b0000;
      clr = 1'b1;
      step();
      clr = 1'b0;
      en = 1'b1; up_dn = 1'b1;
      run_ticks(7);
      en = 1'b0;
      chk("count_0007", {16'd0, cnt_a}, 32'h0007);
      step();
      scan_check("s0007", 32'h3F3F3F07, 32'h00000007);
      clr = 1'b1;
      dp_mask = 4'b1000;
      step();
      clr = 1'b0;
      step();
      scan_check("s0000", 32'hBF3F3F3F, 32'h8000003F);

      // Reset mid-count and mid-scan takes effect without a clock edge
      en = 1'b1; up_dn = 1'b1;
      run_ticks(2);
      step();
      #1 rst = 1'b1;
      #1;
      chk_reset("midrst");
      #1 rst = 1'b0;
      to_tick();
      chk("restart_pre_tick", {16'd0, cnt_a}, 32'h0000);
      step();
      chk("restart_tick", {16'd0, cnt_a}, 32'h0001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
